cpu_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction fetch stage and the shared memory bus. It returns the instruction at the fetch address combinationally on a hit. On a miss it raises `icache_stall`, which is ORed into the global CPU stall, and refills the whole line over a request/acknowledge bus. The fetch stage holds its PC while stalled, so the miss address stays stable for the whole refill.

---
 rtl/cpu_icache_pkg.sv | 30 +++
 rtl/cpu_icache_tags.sv | 46 ++++
 rtl/cpu_icache.sv | 178 +++++++++++++++++
 tb/tb_cpu_icache.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM state encoding, default geometry and address field extraction.
package cpu_icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } icache_state_t;

    localparam int DEF_INDEX_BITS  = 4;
    localparam int DEF_OFFSET_BITS = 2;

    // Word-within-line field, right-justified.
    function automatic logic [31:0] get_word(input logic [31:0] addr, input int offset_bits);
        return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
    endfunction

    // Line index field, right-justified.
    function automatic logic [31:0] get_index(input logic [31:0] addr, input int offset_bits,
                                              input int index_bits);
        return (addr >> (2 + offset_bits)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag field: everything above the index, right-justified.
    function automatic logic [31:0] get_tag(input logic [31:0] addr, input int offset_bits,
                                            input int index_bits);
        return addr >> (2 + offset_bits + index_bits);
    endfunction

endpackage

// File: rtl/cpu_icache_tags.sv
// Valid/tag array: combinational lookup with hit compare, synchronous
// tag write and a single-cycle invalidate of every line.
module cpu_icache_tags
    import cpu_icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_inv,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    input  logic [TAG_BITS-1:0]   i_rd_tag,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic                  i_wr_valid,
    output logic                  o_hit
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag [LINES];

    // Valid bits: cleared by reset or invalidate; invalidate wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_inv) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= i_wr_valid;
        end
    end

    // Tag storage is never cleared; the valid bit guards stale contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_hit = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache with whole-line refill over a
// request/acknowledge bus. Optional statistics counters are enabled by
// defining ICACHE_STATS_EN; otherwise hit_count/miss_count read 0.
module cpu_icache
    import cpu_icache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_stall,
    input  logic        inv,
    input  logic [31:0] imem_addr,
    output logic [31:0] iin,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_BITS  = 32 - 2 - OFFSET_BITS - INDEX_BITS;
    localparam int LINE_BITS = 30 - OFFSET_BITS;
    localparam int ENTRIES   = 1 << (INDEX_BITS + OFFSET_BITS);
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    icache_state_t r_state;
    icache_state_t w_state_nxt;

    logic [OFFSET_BITS-1:0] r_count;
    logic [LINE_BITS-1:0]   r_line;
    logic                   r_poison;
    logic                   r_mem_req;
    logic [31:0]            r_data [ENTRIES];

    logic [OFFSET_BITS-1:0] w_word;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic                   w_hit;
    logic                   w_fill_start;
    logic                   w_fill_done;
    logic                   w_stall;
    logic                   w_wr_valid;

    assign w_word  = OFFSET_BITS'(get_word(imem_addr, OFFSET_BITS));
    assign w_index = INDEX_BITS'(get_index(imem_addr, OFFSET_BITS, INDEX_BITS));
    assign w_tag   = TAG_BITS'(get_tag(imem_addr, OFFSET_BITS, INDEX_BITS));

    // r_line holds the miss address above the word offset: {tag, index}.
    assign w_fill_index = r_line[INDEX_BITS-1:0];
    assign w_fill_tag   = r_line[LINE_BITS-1:INDEX_BITS];

    // A line filled while an invalidate was pending (or arriving now) stays invalid.
    assign w_wr_valid = ~(r_poison | inv);

    cpu_icache_tags #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .i_inv     (inv),
        .i_rd_index(w_index),
        .i_rd_tag  (w_tag),
        .i_wr_en   (w_fill_done),
        .i_wr_index(w_fill_index),
        .i_wr_tag  (w_fill_tag),
        .i_wr_valid(w_wr_valid),
        .o_hit     (w_hit)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stall: miss in IDLE starts a fill, last ack ends it.
    always_comb begin
        w_state_nxt  = r_state;
        w_fill_start = 1'b0;
        w_fill_done  = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_hit) begin
                    w_stall      = 1'b1;
                    w_fill_start = 1'b1;
                    w_state_nxt  = ST_FILL;
                end
            end
            ST_FILL: begin
                w_stall = 1'b1;
                if (mem_ack && (r_count == LAST_WORD)) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Refill bookkeeping: request flag, word counter, line address and poison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req <= 1'b0;
            r_count   <= '0;
            r_poison  <= 1'b0;
            r_line    <= '0;
        end else if (w_fill_start) begin
            r_mem_req <= 1'b1;
            r_count   <= '0;
            r_poison  <= 1'b0;
            r_line    <= imem_addr[31:OFFSET_BITS+2];
        end else if (r_state == ST_FILL) begin
            if (inv) begin
                r_poison <= 1'b1;
            end
            if (mem_ack) begin
                r_count <= r_count + OFFSET_BITS'(1);
                if (w_fill_done) begin
                    r_mem_req <= 1'b0;
                end
            end
        end
    end

    // Data array write, one word per acknowledged bus beat.
    always_ff @(posedge clk) begin
        if ((r_state == ST_FILL) && mem_ack) begin
            r_data[{w_fill_index, r_count}] <= mem_data;
        end
    end

    assign iin          = r_data[{w_index, w_word}];
    assign icache_stall = w_stall;
    assign mem_req      = r_mem_req;
    assign mem_addr     = {r_line, r_count, 2'b00};

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hits counted only in unstalled IDLE cycles; misses once per fill start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_hit && !ext_stall) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fill_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused_ext_stall;
    assign w_unused_ext_stall = ext_stall;
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_icache.sv
// Directed bench for cpu_icache with a behavioural bus responder.
module tb_cpu_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_stall;
    logic        inv;
    logic [31:0] imem_addr;
    logic [31:0] iin;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat = 1;
    int          n_acks = 0;
    int          wcnt = 0;
    logic [31:0] first_addr;
    logic        addr_moved = 1'b0;
    logic [31:0] ack_q[$];
    int          len_q[$];

    cpu_icache dut (
        .clk         (clk),
        .rst         (rst),
        .ext_stall   (ext_stall),
        .inv         (inv),
        .imem_addr   (imem_addr),
        .iin         (iin),
        .icache_stall(icache_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_unstall(output int cyc);
        cyc = 0;
        while (icache_stall && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, output int cyc);
        @(negedge clk);
        imem_addr = a;
        #1;
        wait_unstall(cyc);
    endtask

    task automatic clear_log();
        ack_q.delete();
        len_q.delete();
        n_acks     = 0;
        addr_moved = 1'b0;
    endtask

    // Bus responder: acks each word on its lat-th request cycle.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else begin
                if (wcnt == 0) first_addr = mem_addr;
                else if (mem_addr != first_addr) addr_moved = 1'b1;
                if (wcnt == lat - 1) begin
                    mem_ack  = 1'b1;
                    mem_data = model(mem_addr);
                    ack_q.push_back(mem_addr);
                    len_q.push_back(wcnt + 1);
                    n_acks++;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    initial begin
        int  cyc;
        int  reqs;
        bit  inv_sent;
        rst       = 1'b1;
        ext_stall = 1'b0;
        inv       = 1'b0;
        imem_addr = 32'h100;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_stall", {31'd0, icache_stall}, 32'd1);
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);

        // Cold miss at 0x100, single-cycle acks.
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        #1;
        chk("cold_miss_stall", {31'd0, icache_stall}, 32'd1);
        wait_unstall(cyc);
        chk("cold_stall_cycles", cyc, 5);
        chk("cold_ack_count", ack_q.size(), 4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++)
            chk($sformatf("cold_addr%0d", i), ack_q[i], 32'h100 + 32'(4 * i));
        chk("cold_iin_100", iin, 32'hA0);
        @(negedge clk);
        imem_addr = 32'h10C;
        #1;
        chk("hit_10c_stall", {31'd0, icache_stall}, 32'd0);
        chk("hit_10c_iin", iin, 32'hA3);
        reqs = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (mem_req) reqs++;
        end
        chk("no_req_after_fill", reqs, 0);

        // Conflict on index 0: 0x1100 evicts 0x100, then 0x100 comes back.
        clear_log();
        fetch(32'h1100, cyc);
        chk("conflict_cycles_a", cyc, 5);
        chk("conflict_iin_1100", iin, 32'hDEAD_1100);
        fetch(32'h100, cyc);
        chk("conflict_cycles_b", cyc, 5);
        chk("conflict_iin_100", iin, 32'hA0);
        chk("conflict_acks", n_acks, 8);
`ifdef ICACHE_STATS_EN
        chk("conflict_miss_count", miss_count, 32'd3);
`else
        chk("nostats_miss_count", miss_count, 32'd0);
`endif

        // Wait-state bus: 3 cycles per word.
        lat = 3;
        clear_log();
        fetch(32'h300, cyc);
        chk("ws_stall_cycles", cyc, 13);
        chk("ws_ack_count", ack_q.size(), 4);
        for (int i = 0; i < 4 && i < len_q.size(); i++) begin
            chk($sformatf("ws_len%0d", i), len_q[i], 3);
            chk($sformatf("ws_addr%0d", i), ack_q[i], 32'h300 + 32'(4 * i));
        end
        chk("ws_addr_stable", {31'd0, addr_moved}, 32'd0);
        chk("ws_iin", iin, 32'hDEAD_0300);
        lat = 1;

        // Invalidate at the second ack of the 0x200 fill: fill completes, then refills.
        clear_log();
        inv_sent = 1'b0;
        @(negedge clk);
        imem_addr = 32'h200;
        #1;
        cyc = 0;
        while (icache_stall && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!inv_sent && mem_ack && n_acks == 2) begin
                inv      = 1'b1;
                inv_sent = 1'b1;
            end else begin
                inv = 1'b0;
            end
            #1;
        end
        inv = 1'b0;
        chk("inv_fill_sent", {31'd0, inv_sent}, 32'd1);
        chk("inv_fill_cycles", cyc, 10);
        chk("inv_fill_acks", n_acks, 8);
        chk("inv_fill_iin", iin, 32'hDEAD_0200);

        // Invalidate while idle on a hitting line.
        @(negedge clk);
        inv = 1'b1;
        #1;
        chk("inv_idle_hit_before", {31'd0, icache_stall}, 32'd0);
        @(negedge clk);
        inv = 1'b0;
        #1;
        chk("inv_idle_miss_after", {31'd0, icache_stall}, 32'd1);
        wait_unstall(cyc);
        chk("inv_idle_refill_cycles", cyc, 5);

        // Reset after two acks of the 0x400 fill.
        clear_log();
        @(negedge clk);
        imem_addr = 32'h400;
        cyc = 0;
        while (!(mem_ack && n_acks == 2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached", n_acks, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, icache_stall}, 32'd1);
        clear_log();
        wait_unstall(cyc);
        chk("rst_refill_cycles", cyc, 5);
        chk("rst_refill_acks", ack_q.size(), 4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++)
            chk($sformatf("rst_addr%0d", i), ack_q[i], 32'h400 + 32'(4 * i));
        chk("rst_refill_iin", iin, 32'hDEAD_0400);

        // Statistics: 10 hit cycles, ext_stall on 4 of them.
`ifdef ICACHE_STATS_EN
        chk("stats_hit_start", hit_count, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            ext_stall = (i < 4);
            @(negedge clk);
        end
        ext_stall = 1'b1;
        #1;
`ifdef ICACHE_STATS_EN
        chk("stats_hit_count", hit_count, 32'd6);
        chk("stats_miss_count", miss_count, 32'd1);
`else
        chk("nostats_hit_count", hit_count, 32'd0);
        chk("nostats_miss_count_end", miss_count, 32'd0);
`endif
        chk("stats_still_hit", {31'd0, icache_stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
